// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline.
// It produces the stall, flush and forward-select controls, and it drives a
// memory-wait FSM with a timeout watchdog. It also keeps two saturating
// performance counters: stall cycles and branch-flush cycles.
module pipeline_hazard_ctrl #(
    parameter logic [1:0] LOAD_WB_SRC = 2'b01,
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             regwrite_E,
    input  logic             regwrite_M,
    input  logic             regwrite_W,
    input  logic [1:0]       wb_src_E,
    input  logic             pcsrc_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // The wait counter must be able to hold values up to MEM_TIMEOUT-1.
    localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_HALT} state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             branch_flush;
    logic             mw;
    logic             lu;

    // Memory wait: a request is outstanding and the memory has not completed.
    assign mw = dmem_req_M & ~dmem_ready;
    // Load-use: a load in EX writes a register that the ID instruction reads.
    // x0 is excluded.
    assign lu = regwrite_E && (wb_src_E == LOAD_WB_SRC) && (RD_E != 5'd0)
                && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    // Operand forwarding. Index 0 is operand A and index 1 is operand B.
    // MEM has priority over WB. x0 is never forwarded.
    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd;
    assign rs_e = {Rs2_E, Rs1_E};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_m;
            logic hit_w;
            assign hit_m   = regwrite_M && (RD_M != 5'd0) && (RD_M == rs_e[gi]);
            assign hit_w   = regwrite_W && (RD_W != 5'd0) && (RD_W == rs_e[gi]);
            assign fwd[gi] = rst   ? 2'b00 :
                             hit_m ? 2'b10 :
                             hit_w ? 2'b01 : 2'b00;
        end
    endgenerate

    assign fwdA_E = fwd[0];
    assign fwdB_E = fwd[1];

    // Next-state and control outputs.
    // Priority is HALT, then memory wait, then branch, then load-use.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        stall_F      = 1'b0;
        stall_D      = 1'b0;
        stall_E      = 1'b0;
        stall_M      = 1'b0;
        flush_D      = 1'b0;
        flush_E      = 1'b0;
        flush_W      = 1'b0;
        branch_flush = 1'b0;
        if (!rst) begin
            if (state_q == ST_HALT) begin
                {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
                flush_W = 1'b1;
            end else if (mw) begin
                // Freeze everything up to MEM and drop a bubble into WB.
                {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
                flush_W = 1'b1;
                if (state_q == ST_RUN) begin
                    if (MEM_TIMEOUT <= 1) begin
                        state_d   = ST_HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d    = ST_MEMWAIT;
                        wait_cnt_d = WC_W'(1);
                    end
                end else if (wait_cnt_q == WC_LAST) begin
                    state_d   = ST_HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end else begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
                if (pcsrc_E) begin
                    flush_D      = 1'b1;
                    flush_E      = 1'b1;
                    branch_flush = 1'b1;
                end else if (lu) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_F && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State, watchdog and counter registers. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Each step pushes its expected controls to a scoreboard queue. The entry is
// popped and compared mid-cycle. After the clock edge the counters and
// mem_err are compared against a small saturating model.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W  = 4;
    localparam int TMO    = 4;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic regwrite_E, regwrite_M, regwrite_W;
    logic [1:0] wb_src_E;
    logic pcsrc_E, dmem_req_M, dmem_ready;
    logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0] fwdA_E, fwdB_E;
    logic mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(
        .LOAD_WB_SRC (2'b01),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .wb_src_E(wb_src_E), .pcsrc_E(pcsrc_E),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
    typedef struct {
        logic [6:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       me;
        logic       in_rst;
    } exp_t;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MW   = 7'b1111001;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
        RD_E = 0; RD_M = 0; RD_W = 0;
        regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
        wb_src_E = 2'b00; pcsrc_E = 0; dmem_req_M = 0; dmem_ready = 0;
    endtask

    task automatic set_lu();
        regwrite_E = 1'b1; wb_src_E = 2'b01; RD_E = 5'd5; Rs1_D = 5'd5;
    endtask

    // One cycle: push the expectation, check the controls mid-cycle, then
    // check the registered state after the edge.
    task automatic step(input logic [6:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic me);
        exp_t e, g;
        e.ctl = ctl; e.fa = fa; e.fb = fb; e.me = me; e.in_rst = rst;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk("ctl", 32'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}), 32'(g.ctl));
        chk("fwdA", 32'(fwdA_E), 32'(g.fa));
        chk("fwdB", 32'(fwdB_E), 32'(g.fb));
        @(posedge clk);
        #1;
        if (g.in_rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (g.ctl[6] && m_stall != CMAX) m_stall = m_stall + 1'b1;
            if (g.ctl[2] && m_flush != CMAX) m_flush = m_flush + 1'b1;
        end
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("mem_err", 32'(mem_err), 32'(g.me));
        $display("step %0d ctl=%b fwdA=%b fwdB=%b stall_cnt=%0d flush_cnt=%0d mem_err=%b",
                 step_no, {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W},
                 fwdA_E, fwdB_E, stall_cnt, flush_cnt, mem_err);
        step_no++;
    endtask

    initial begin
        // Reset with hazards present: every output must be gated off.
        idle(); rst = 1'b1; set_lu(); pcsrc_E = 1'b1; dmem_req_M = 1'b1;
        regwrite_M = 1'b1; RD_M = 5'd7; Rs1_E = 5'd7;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        idle(); rst = 1'b1;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        idle();
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        // Load-use through Rs1_D and then through Rs2_D.
        set_lu();
        step(C_LU, 2'b00, 2'b00, 1'b0);
        Rs1_D = 5'd0; Rs2_D = 5'd5;
        step(C_LU, 2'b00, 2'b00, 1'b0);
        // Not a load-use: RD_E is x0, or the instruction in EX is not a load.
        RD_E = 5'd0; Rs2_D = 5'd0;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        RD_E = 5'd5; Rs1_D = 5'd5; wb_src_E = 2'b00;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        wb_src_E = 2'b10;
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        // A branch takes priority over a load-use.
        set_lu(); pcsrc_E = 1'b1;
        step(C_BR, 2'b00, 2'b00, 1'b0);
        idle();

        // Forwarding cases.
        regwrite_M = 1'b1; regwrite_W = 1'b1; RD_M = 5'd7; RD_W = 5'd7;
        Rs1_E = 5'd7; Rs2_E = 5'd0;
        step(C_NONE, 2'b10, 2'b00, 1'b0);
        RD_M = 5'd0; RD_W = 5'd0; Rs1_E = 5'd0;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        RD_M = 5'd9; RD_W = 5'd7; Rs1_E = 5'd7; Rs2_E = 5'd9;
        step(C_NONE, 2'b01, 2'b10, 1'b0);
        regwrite_M = 1'b0;
        step(C_NONE, 2'b01, 2'b00, 1'b0);
        regwrite_W = 1'b0;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        idle();

        // Three wait cycles with a branch and a load-use pending behind them.
        set_lu(); pcsrc_E = 1'b1; dmem_req_M = 1'b1;
        for (int i = 0; i < 3; i++) step(C_MW, 2'b00, 2'b00, 1'b0);
        dmem_ready = 1'b1;
        step(C_BR, 2'b00, 2'b00, 1'b0);
        idle();
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        // A zero-wait access does not stall.
        dmem_req_M = 1'b1; dmem_ready = 1'b1;
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        // Timeout after 4 wait cycles, then HALT until reset.
        dmem_ready = 1'b0;
        for (int i = 0; i < TMO; i++) step(C_MW, 2'b00, 2'b00, (i == TMO - 1));
        idle(); pcsrc_E = 1'b1;
        step(C_MW, 2'b00, 2'b00, 1'b1);
        idle();
        step(C_MW, 2'b00, 2'b00, 1'b1);
        rst = 1'b1;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        idle();
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        // A reset in the middle of a wait restarts the watchdog from zero.
        dmem_req_M = 1'b1;
        for (int i = 0; i < 2; i++) step(C_MW, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        step(C_NONE, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step(C_MW, 2'b00, 2'b00, 1'b0);
        idle();
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        // The stall counter saturates and does not wrap.
        set_lu();
        for (int i = 0; i < 20; i++) step(C_LU, 2'b00, 2'b00, 1'b0);
        idle(); pcsrc_E = 1'b1;
        for (int i = 0; i < 3; i++) step(C_BR, 2'b00, 2'b00, 1'b0);
        idle();
        step(C_NONE, 2'b00, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
